// File: rtl/hp_pkg.sv
// Shared types and word-size constants for the hash-pipe sweep harness.
package hp_pkg;

  localparam int unsigned WORDBITS  = 32;
  localparam int unsigned HASHWORDS = 8;
  localparam int unsigned MSGWORDS  = 16;
  localparam int unsigned HASHBITS  = HASHWORDS * WORDBITS;
  localparam int unsigned MSGBITS   = MSGWORDS * WORDBITS;

  typedef enum logic [0:0] {
    IDLE,
    SWEEP
  } hp_state_t;

  typedef struct packed {
    logic [HASHBITS-1:0] hash;
    logic [WORDBITS-1:0] nonce;
  } resp_entry_t;

endpackage

// File: rtl/hp_pipe_core.sv
// Fixed-latency hash pipe core: a word-mixing round followed by a plain delay line,
// so a_h_out reflects msg_in exactly PIPE_LAT clocks later. No reset on purpose.
module hp_pipe_core
  import hp_pkg::*;
#(
  parameter int unsigned PIPE_LAT = 64
) (
  input  logic                clk,
  input  logic [MSGBITS-1:0]  msg_in,
  output logic [HASHBITS-1:0] a_h_out
);

  logic [HASHBITS-1:0] r_stage [PIPE_LAT];

  function automatic logic [HASHBITS-1:0] mix(input logic [MSGBITS-1:0] m);
    logic [HASHBITS-1:0] h;
    logic [WORDBITS-1:0] a, b, c;
    h = '0;
    for (int k = 0; k < HASHWORDS; k++) begin
      a = m[k*WORDBITS +: WORDBITS];
      b = m[((k + HASHWORDS) % MSGWORDS)*WORDBITS +: WORDBITS];
      c = m[((k + 3) % MSGWORDS)*WORDBITS +: WORDBITS];
      h[k*WORDBITS +: WORDBITS] = (a ^ b) + c * WORDBITS'(32'h9E3779B1);
    end
    return h;
  endfunction

  always_ff @(posedge clk) begin
    r_stage[0] <= mix(msg_in);
    for (int i = 1; i < PIPE_LAT; i++) begin
      r_stage[i] <= r_stage[i-1];
    end
  end

  assign a_h_out = r_stage[PIPE_LAT-1];

endmodule

// File: rtl/hp_resp_fifo.sv
// First-word fall-through FIFO with occupancy count; read data reads as zero when empty.
module hp_resp_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 8,
  localparam int unsigned AW   = $clog2(Depth),
  localparam int unsigned CW   = AW + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr,
  input  logic [Width-1:0] i_wdata,
  input  logic             i_rd,
  output logic             o_valid,
  output logic [Width-1:0] o_rdata,
  output logic [CW-1:0]    o_count,
  output logic             o_full
);

  logic [Width-1:0] r_mem [Depth];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_do_wr, w_do_rd;

  assign o_valid = (r_count != '0);
  assign o_full  = (r_count == CW'(Depth));
  assign o_count = r_count;
  assign w_do_wr = i_wr && !o_full;
  assign w_do_rd = i_rd && o_valid;
  assign o_rdata = o_valid ? r_mem[r_rptr] : '0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_wr) r_wptr <= r_wptr + 1'b1;
      if (w_do_rd) r_rptr <= r_rptr + 1'b1;
      if (w_do_wr && !w_do_rd) begin
        r_count <= r_count + 1'b1;
      end else if (!w_do_wr && w_do_rd) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_wr) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/hp_sweep_harness.sv
// Nonce-sweep driver around hp_pipe_core; credits bound in-flight plus buffered results
// to the FIFO depth so no result can be dropped under back-pressure.
module hp_sweep_harness
  import hp_pkg::*;
#(
  parameter int unsigned PIPE_LAT   = 64,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned NONCE_WORD = 3,
  parameter int unsigned COUNTW     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [MSGBITS-1:0]  req_msg,
  input  logic [COUNTW-1:0]   req_count,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [HASHBITS-1:0] resp_hash,
  output logic [WORDBITS-1:0] resp_nonce,
  output logic                busy
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  hp_state_t           r_state, w_state_next;
  logic                r_live;
  logic [MSGBITS-1:0]  r_msg, r_core_msg, w_issue_msg;
  logic [WORDBITS-1:0] r_nonce, r_core_nonce;
  logic [COUNTW-1:0]   r_remaining;
  logic                r_core_vld;
  logic                r_vsr [PIPE_LAT];
  logic [WORDBITS-1:0] r_nsr [PIPE_LAT];
  logic [CW-1:0]       r_inflight, w_fifo_count;
  logic [CW:0]         w_credit;
  logic                w_accept, w_issue, w_fifo_wr, w_fifo_full, w_pop;
  logic [HASHBITS-1:0] w_core_hash;
  resp_entry_t         w_wr_entry, w_head;

  always_comb begin
    w_state_next = r_state;
    req_ready    = 1'b0;
    w_accept     = 1'b0;
    w_issue      = 1'b0;
    w_credit     = (CW+1)'(r_inflight) + (CW+1)'(w_fifo_count);
    unique case (r_state)
      IDLE: begin
        // r_live keeps req_ready low until the first edge after reset release
        req_ready = r_live;
        w_accept  = req_valid && r_live;
        if (w_accept) w_state_next = SWEEP;
      end
      SWEEP: begin
        w_issue = (w_credit < (CW+1)'(FIFO_DEPTH));
        if (w_issue && (r_remaining == COUNTW'(1))) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_live  <= 1'b1;
    end
  end

  always_comb begin
    w_issue_msg = r_msg;
    w_issue_msg[NONCE_WORD*WORDBITS +: WORDBITS] = r_nonce;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_msg       <= '0;
      r_nonce     <= '0;
      r_remaining <= '0;
      r_core_msg  <= '0;
      r_core_vld  <= 1'b0;
      r_inflight  <= '0;
      for (int i = 0; i < PIPE_LAT; i++) r_vsr[i] <= 1'b0;
    end else begin
      if (w_accept) begin
        r_msg       <= req_msg;
        r_nonce     <= req_msg[NONCE_WORD*WORDBITS +: WORDBITS];
        r_remaining <= (req_count == '0) ? COUNTW'(1) : req_count;
      end
      if (w_issue) begin
        r_core_msg  <= w_issue_msg;
        r_nonce     <= r_nonce + 1'b1;
        r_remaining <= r_remaining - 1'b1;
      end
      r_core_vld <= w_issue;
      r_vsr[0]   <= r_core_vld;
      for (int i = 1; i < PIPE_LAT; i++) r_vsr[i] <= r_vsr[i-1];
      if (w_issue && !w_fifo_wr) begin
        r_inflight <= r_inflight + 1'b1;
      end else if (!w_issue && w_fifo_wr) begin
        r_inflight <= r_inflight - 1'b1;
      end
    end
  end

  // Nonce tags only matter where their valid bit is set, so they need no reset
  always_ff @(posedge clk) begin
    if (w_issue) r_core_nonce <= r_nonce;
    r_nsr[0] <= r_core_nonce;
    for (int i = 1; i < PIPE_LAT; i++) r_nsr[i] <= r_nsr[i-1];
  end

  hp_pipe_core #(
    .PIPE_LAT (PIPE_LAT)
  ) u_core (
    .clk     (clk),
    .msg_in  (r_core_msg),
    .a_h_out (w_core_hash)
  );

  assign w_fifo_wr        = r_vsr[PIPE_LAT-1];
  assign w_wr_entry.hash  = w_core_hash;
  assign w_wr_entry.nonce = r_nsr[PIPE_LAT-1];
  assign w_pop            = resp_valid && resp_ready;

  hp_resp_fifo #(
    .Width ($bits(resp_entry_t)),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_wr    (w_fifo_wr),
    .i_wdata (w_wr_entry),
    .i_rd    (w_pop),
    .o_valid (resp_valid),
    .o_rdata (w_head),
    .o_count (w_fifo_count),
    .o_full  (w_fifo_full)
  );

  assign resp_hash  = w_head.hash;
  assign resp_nonce = w_head.nonce;
  assign busy       = (r_state == SWEEP) || (r_inflight != '0) || (w_fifo_count != '0);

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) w_fifo_wr |-> !w_fifo_full);

endmodule
